// File: rtl/spi_slave_burst.sv
// SPI register-access slave: mode bit, address, then a burst of data words.
// All SPI pins are resynchronised into clk; addresses auto-increment per word.
module spi_slave_burst #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8,
  parameter int CPOL   = 0,
  parameter int CPHA   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs_n,
  input  logic              sclk,
  input  logic              mosi,
  output logic              miso,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_w,
  output logic              write_vld,
  output logic              read_en,
  input  logic [DATA_W-1:0] data_r,
  output logic              busy,
  output logic              frame_abort
);

  localparam int   CNT_W     = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) + 1);
  localparam logic SCLK_IDLE = (CPOL != 0);

  typedef enum logic [1:0] {IDLE, CMD, ADDR, DATA} state_t;

  state_t            state, state_nx;
  logic [1:0]        cs_sync, sclk_sync, mosi_sync;
  logic              cs_d, sclk_d;
  logic              cs_s, sclk_s, mosi_s;
  logic              rise, fall, lead, trail, sample, shift_e, cs_fall;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] addr_sh, addr_nx;
  logic [DATA_W-1:0] rx_sh, rx_nx, tx_sh;
  logic              mode_rd, miso_q, load_p1;
  logic              addr_last, data_last, word_done, abort_now;

  // Stage p0: pin synchronisers and edge history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= 2'b11;
      sclk_sync <= {2{SCLK_IDLE}};
      mosi_sync <= 2'b00;
      cs_d      <= 1'b1;
      sclk_d    <= SCLK_IDLE;
    end else begin
      cs_sync   <= {cs_sync[0], cs_n};
      sclk_sync <= {sclk_sync[0], sclk};
      mosi_sync <= {mosi_sync[0], mosi};
      cs_d      <= cs_sync[1];
      sclk_d    <= sclk_sync[1];
    end
  end

  assign cs_s    = cs_sync[1];
  assign sclk_s  = sclk_sync[1];
  assign mosi_s  = mosi_sync[1];
  assign rise    = sclk_s & ~sclk_d;
  assign fall    = ~sclk_s & sclk_d;
  assign lead    = SCLK_IDLE ? fall : rise;
  assign trail   = SCLK_IDLE ? rise : fall;
  assign sample  = (CPHA != 0) ? trail : lead;
  assign shift_e = (CPHA != 0) ? lead : trail;
  assign cs_fall = cs_d & ~cs_s;

  assign addr_last = (bit_cnt == CNT_W'(ADDR_W - 1));
  assign data_last = (bit_cnt == CNT_W'(DATA_W - 1));
  assign addr_nx   = {addr_sh[ADDR_W-2:0], mosi_s};
  assign rx_nx     = {rx_sh[DATA_W-2:0], mosi_s};

  // A word or field finishing on the same clk that cs_n rises is a clean end
  assign word_done = sample && ((state == CMD) ||
                                (state == ADDR && addr_last) ||
                                (state == DATA && data_last));
  assign abort_now = cs_s && (state != IDLE) && (bit_cnt != '0) && !word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (cs_s) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_nx = CMD;
        CMD:     if (sample) state_nx = ADDR;
        ADDR:    if (sample && addr_last) state_nx = DATA;
        DATA:    state_nx = DATA;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Stage p1: field decode, register-side strobes and tx shifting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      data_w      <= '0;
      write_vld   <= 1'b0;
      read_en     <= 1'b0;
      frame_abort <= 1'b0;
      bit_cnt     <= '0;
      addr_sh     <= '0;
      rx_sh       <= '0;
      tx_sh       <= '0;
      mode_rd     <= 1'b0;
      miso_q      <= 1'b0;
      load_p1     <= 1'b0;
    end else begin
      write_vld   <= 1'b0;
      read_en     <= 1'b0;
      frame_abort <= abort_now;
      load_p1     <= read_en;
      if (write_vld) addr <= addr + ADDR_W'(1);
      case (state)
        CMD: if (sample) mode_rd <= mosi_s;
        ADDR: begin
          if (sample) begin
            addr_sh <= addr_nx;
            if (addr_last) begin
              bit_cnt <= '0;
              addr    <= addr_nx;
              read_en <= mode_rd;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        DATA: begin
          if (sample) begin
            if (!mode_rd) rx_sh <= rx_nx;
            if (data_last) begin
              bit_cnt <= '0;
              if (mode_rd) begin
                addr    <= addr + ADDR_W'(1);
                read_en <= 1'b1;
              end else begin
                data_w    <= rx_nx;
                write_vld <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
          // With CPHA=0 the MSB is already on miso, so the first shift edge of a word is skipped
          if (mode_rd && shift_e && ((CPHA != 0) || (bit_cnt != '0))) begin
            miso_q <= tx_sh[DATA_W-1];
            tx_sh  <= tx_sh << 1;
          end
        end
        default: ;
      endcase
      if (load_p1) begin
        if (CPHA == 0) begin
          miso_q <= data_r[DATA_W-1];
          tx_sh  <= data_r << 1;
        end else begin
          tx_sh  <= data_r;
        end
      end
      if (state == IDLE && cs_fall) begin
        bit_cnt <= '0;
        addr    <= '0;
        miso_q  <= 1'b0;
      end
    end
  end

  assign miso = miso_q & mode_rd & (state == DATA);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_spi_slave_burst.sv
// Bench for spi_slave_burst: three instances (modes 0, 3 and 1) driven by a bit-level SPI
// master, with a register-file model supplying read data and predicting all strobes.
module tb_spi_slave_burst;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int NDUT   = 3;
  localparam int HALF   = 80;

  typedef struct { int dut; int a; int d; } ev_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              cs_n [NDUT];
  logic              sclk [NDUT];
  logic              mosi [NDUT];
  logic              miso [NDUT];
  logic [ADDR_W-1:0] addr [NDUT];
  logic [DATA_W-1:0] data_w [NDUT];
  logic [DATA_W-1:0] data_r [NDUT];
  logic              write_vld [NDUT];
  logic              read_en [NDUT];
  logic              busy [NDUT];
  logic              frame_abort [NDUT];

  logic [DATA_W-1:0] mem [128];
  ev_t  wr_q[$];
  ev_t  rd_q[$];
  ev_t  mon_e;
  int   abort_cnt = 0;
  bit   tx_bits[$];
  bit   rx_bits[$];
  int   wdata[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  spi_slave_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPOL(0), .CPHA(0)) u_mode0 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n[0]), .sclk(sclk[0]), .mosi(mosi[0]), .miso(miso[0]),
    .addr(addr[0]), .data_w(data_w[0]), .write_vld(write_vld[0]), .read_en(read_en[0]),
    .data_r(data_r[0]), .busy(busy[0]), .frame_abort(frame_abort[0]));

  spi_slave_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPOL(1), .CPHA(1)) u_mode3 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n[1]), .sclk(sclk[1]), .mosi(mosi[1]), .miso(miso[1]),
    .addr(addr[1]), .data_w(data_w[1]), .write_vld(write_vld[1]), .read_en(read_en[1]),
    .data_r(data_r[1]), .busy(busy[1]), .frame_abort(frame_abort[1]));

  spi_slave_burst #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CPOL(0), .CPHA(1)) u_mode1 (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n[2]), .sclk(sclk[2]), .mosi(mosi[2]), .miso(miso[2]),
    .addr(addr[2]), .data_w(data_w[2]), .write_vld(write_vld[2]), .read_en(read_en[2]),
    .data_r(data_r[2]), .busy(busy[2]), .frame_abort(frame_abort[2]));

  always #5 clk = ~clk;

  // Register file: answers a read request with one clk of latency
  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++)
      if (read_en[i]) data_r[i] <= mem[addr[i]];
  end

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (write_vld[i]) begin
        mon_e.dut = i; mon_e.a = int'(addr[i]); mon_e.d = int'(data_w[i]);
        wr_q.push_back(mon_e);
      end
      if (read_en[i]) begin
        mon_e.dut = i; mon_e.a = int'(addr[i]); mon_e.d = 0;
        rd_q.push_back(mon_e);
      end
      if (frame_abort[i]) abort_cnt++;
    end
  end

  function automatic bit cpol_of(int m);
    return (m == 1);
  endfunction

  function automatic bit cpha_of(int m);
    return (m != 0);
  endfunction

  function automatic void push_field(int v, int n);
    for (int k = n - 1; k >= 0; k--) tx_bits.push_back(bit'((v >> k) & 1));
  endfunction

  // One SPI bit; raise_cs lifts cs_n at the very instant of the slave's sample edge
  task automatic xfer_bit(int m, bit mo, bit raise_cs, output bit mi);
    bit pol;
    pol = cpol_of(m);
    if (!cpha_of(m)) begin
      mosi[m] = mo;
      #HALF;
      mi = miso[m];
      sclk[m] = ~pol;
      if (raise_cs) cs_n[m] = 1'b1;
      #HALF;
      sclk[m] = pol;
    end else begin
      sclk[m] = ~pol;
      mosi[m] = mo;
      #HALF;
      mi = miso[m];
      sclk[m] = pol;
      if (raise_cs) cs_n[m] = 1'b1;
      #HALF;
    end
  endtask

  task automatic run_frame(int m, bit early_cs);
    bit mi;
    rx_bits.delete();
    cs_n[m] = 1'b0;
    #HALF;
    for (int k = 0; k < tx_bits.size(); k++) begin
      xfer_bit(m, tx_bits[k], early_cs && (k == tx_bits.size() - 1), mi);
      rx_bits.push_back(mi);
    end
    if (!early_cs) begin
      #HALF;
      cs_n[m] = 1'b1;
    end
    mosi[m] = 1'b0;
    repeat (24) @(posedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NDUT; i++) begin
      n_tests++;
      if ({addr[i], data_w[i], write_vld[i], read_en[i], miso[i], busy[i], frame_abort[i]} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs dut%0d: got addr=%0h data_w=%0h wv=%0b re=%0b miso=%0b busy=%0b abort=%0b, required all 0",
                 i, addr[i], data_w[i], write_vld[i], read_en[i], miso[i], busy[i], frame_abort[i]);
      end
    end
  endtask

  task automatic test_write(int m, int a);
    int w0, r0, ab0;
    w0 = wr_q.size(); r0 = rd_q.size(); ab0 = abort_cnt;
    tx_bits.delete();
    push_field(0, 1);
    push_field(a, ADDR_W);
    foreach (wdata[i]) push_field(wdata[i], DATA_W);
    run_frame(m, 1'b0);
    n_tests++;
    if (wr_q.size() - w0 !== wdata.size()) begin
      n_fail++;
      $display("FAIL write_count dut%0d addr=%02h: got %0d required %0d", m, a, wr_q.size() - w0, wdata.size());
    end
    for (int i = 0; i < wdata.size() && w0 + i < wr_q.size(); i++) begin
      n_tests++;
      if (wr_q[w0+i].dut !== m || wr_q[w0+i].a !== ((a + i) % 128) || wr_q[w0+i].d !== wdata[i]) begin
        n_fail++;
        $display("FAIL write_word%0d dut%0d: got dut%0d (%02h,%02h) required dut%0d (%02h,%02h)", i, m,
                 wr_q[w0+i].dut, wr_q[w0+i].a, wr_q[w0+i].d, m, (a + i) % 128, wdata[i]);
      end
    end
    n_tests++;
    if (abort_cnt - ab0 !== 0 || rd_q.size() - r0 !== 0) begin
      n_fail++;
      $display("FAIL write_side_effects dut%0d: got aborts=%0d reads=%0d required 0 and 0", m, abort_cnt - ab0, rd_q.size() - r0);
    end
  endtask

  task automatic test_read(int m, int a, int nw);
    int w0, r0, ab0;
    logic [DATA_W-1:0] got, hdr;
    w0 = wr_q.size(); r0 = rd_q.size(); ab0 = abort_cnt;
    tx_bits.delete();
    push_field(1, 1);
    push_field(a, ADDR_W);
    for (int i = 0; i < nw; i++) push_field($urandom_range(0, 255), DATA_W);
    run_frame(m, 1'b0);
    n_tests++;
    if (rd_q.size() - r0 !== nw + 1) begin
      n_fail++;
      $display("FAIL read_en_count dut%0d addr=%02h: got %0d required %0d", m, a, rd_q.size() - r0, nw + 1);
    end
    for (int i = 0; i <= nw && r0 + i < rd_q.size(); i++) begin
      n_tests++;
      if (rd_q[r0+i].dut !== m || rd_q[r0+i].a !== ((a + i) % 128)) begin
        n_fail++;
        $display("FAIL read_en_addr%0d dut%0d: got dut%0d addr %02h required %02h", i, m, rd_q[r0+i].dut, rd_q[r0+i].a, (a + i) % 128);
      end
    end
    hdr = '0;
    for (int j = 0; j < 8; j++) hdr = {hdr[DATA_W-2:0], rx_bits[j]};
    n_tests++;
    if (hdr !== '0) begin
      n_fail++;
      $display("FAIL miso_header dut%0d: got %08b required 00000000", m, hdr);
    end
    for (int i = 0; i < nw; i++) begin
      got = '0;
      for (int j = 0; j < DATA_W; j++) got = {got[DATA_W-2:0], rx_bits[8 + i*DATA_W + j]};
      n_tests++;
      if (got !== mem[(a + i) % 128]) begin
        n_fail++;
        $display("FAIL miso_word%0d dut%0d: got %08b required %08b", i, m, got, mem[(a + i) % 128]);
      end
    end
    n_tests++;
    if (abort_cnt - ab0 !== 0 || wr_q.size() - w0 !== 0) begin
      n_fail++;
      $display("FAIL read_side_effects dut%0d: got aborts=%0d writes=%0d required 0 and 0", m, abort_cnt - ab0, wr_q.size() - w0);
    end
  endtask

  task automatic test_abort(int m);
    int w0, ab0;
    w0 = wr_q.size(); ab0 = abort_cnt;
    tx_bits.delete();
    push_field(0, 1);
    push_field($urandom_range(0, 127), ADDR_W);
    push_field($urandom_range(0, 15), 4);
    run_frame(m, 1'b0);
    n_tests++;
    if (wr_q.size() - w0 !== 0) begin
      n_fail++;
      $display("FAIL abort_no_write dut%0d: got %0d writes required 0", m, wr_q.size() - w0);
    end
    n_tests++;
    if (abort_cnt - ab0 !== 1) begin
      n_fail++;
      $display("FAIL abort_pulse dut%0d: got %0d pulses required 1", m, abort_cnt - ab0);
    end
    wdata = '{$urandom_range(0, 255)};
    test_write(m, $urandom_range(0, 127));
  endtask

  task automatic test_cs_on_last_edge(int m);
    int w0, ab0, a, d;
    w0 = wr_q.size(); ab0 = abort_cnt;
    a = $urandom_range(0, 127); d = $urandom_range(0, 255);
    tx_bits.delete();
    push_field(0, 1);
    push_field(a, ADDR_W);
    push_field(d, DATA_W);
    run_frame(m, 1'b1);
    n_tests++;
    if (wr_q.size() - w0 !== 1 || wr_q[wr_q.size()-1].a !== a || wr_q[wr_q.size()-1].d !== d) begin
      n_fail++;
      $display("FAIL cs_on_last_edge_write dut%0d: got %0d writes, last (%02h,%02h) required 1 write (%02h,%02h)",
               m, wr_q.size() - w0, wr_q[wr_q.size()-1].a, wr_q[wr_q.size()-1].d, a, d);
    end
    n_tests++;
    if (abort_cnt - ab0 !== 0) begin
      n_fail++;
      $display("FAIL cs_on_last_edge_abort dut%0d: got %0d pulses required 0", m, abort_cnt - ab0);
    end
  endtask

  task automatic test_reset_midframe();
    bit mi;
    cs_n[0] = 1'b0;
    #HALF;
    xfer_bit(0, 1'b0, 1'b0, mi);
    for (int k = 0; k < 3; k++) xfer_bit(0, bit'($urandom_range(0, 1)), 1'b0, mi);
    n_tests++;
    if (busy[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_midframe: got %0b required 1", busy[0]);
    end
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({addr[0], data_w[0], write_vld[0], read_en[0], miso[0], busy[0], frame_abort[0]} !== '0) begin
      n_fail++;
      $display("FAIL reset_midframe: got addr=%0h data_w=%0h busy=%0b, required all 0", addr[0], data_w[0], busy[0]);
    end
    cs_n[0] = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    wdata = '{$urandom_range(0, 255), $urandom_range(0, 255)};
    test_write(0, $urandom_range(0, 127));
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int m, a, n;
      m = $urandom_range(0, NDUT - 1);
      a = $urandom_range(0, 127);
      n = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) begin
        test_read(m, a, n);
      end else begin
        wdata.delete();
        for (int i = 0; i < n; i++) wdata.push_back($urandom_range(0, 255));
        test_write(m, a);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      cs_n[i] = 1'b1;
      sclk[i] = cpol_of(i);
      mosi[i] = 1'b0;
    end
    for (int i = 0; i < 128; i++) mem[i] = DATA_W'($urandom_range(0, 255));
    repeat (3) @(posedge clk);
    test_reset();
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);
    test_reset();

    mem[5] = 8'h3C;
    mem[6] = 8'hC3;
    for (int m = 0; m < NDUT; m++) begin
      wdata = '{8'hA5};
      test_write(m, 8'h01);
      test_read(m, 8'h05, 2);
    end
    wdata = '{8'h11, 8'h22, 8'h33};
    test_write(0, 8'h7F);
    test_abort(0);
    test_cs_on_last_edge(0);
    test_cs_on_last_edge(2);
    test_reset_midframe();
    test_random();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
